// File: rtl/bcd_disp_mux.sv
// Two-digit multiplexed 7-segment driver for a packed BCD count.
// Latches a tear-free snapshot once per frame and scans ones then tens.
module bcd_disp_mux #(
   parameter int unsigned REFRESH_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] bcd_in,
   input  logic       blank_lz,
   output logic [1:0] an,
   output logic [6:0] seg,
   output logic       frame_done,
   output logic       err
);

   localparam int unsigned CNT_W = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ONES = 2'd1,
      TENS = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       snap_q, snap_d;
   logic             lz_q, lz_d;
   logic             err_q, err_d;
   logic             fd_q, fd_d;
   logic             tick;
   logic             load;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   assign tick = en && (cnt_q == CNT_LAST);
   // Snapshot only at frame starts so a digit pair is never torn mid-scan.
   assign load = tick && ((state_q == IDLE) || (state_q == TENS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         snap_q  <= '0;
         lz_q    <= 1'b0;
         err_q   <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         lz_q    <= lz_d;
         err_q   <= err_d;
         fd_q    <= fd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      lz_d    = lz_q;
      err_d   = err_q;
      fd_d    = 1'b0;
      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
         case (state_q)
            IDLE: if (tick) state_d = ONES;
            ONES: if (tick) state_d = TENS;
            TENS: begin
               if (tick) begin
                  state_d = ONES;
                  fd_d    = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (load) begin
         snap_d = bcd_in;
         lz_d   = blank_lz;
         err_d  = (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
      end
   end

   always_comb begin
      an  = 2'b00;
      seg = 7'h00;
      case (state_q)
         ONES: begin
            an  = 2'b01;
            seg = seg_decode(snap_q[3:0]);
         end
         TENS: begin
            an  = 2'b10;
            seg = (lz_q && (snap_q[7:4] == 4'd0)) ? 7'h00 : seg_decode(snap_q[7:4]);
         end
         default: begin
            an  = 2'b00;
            seg = 7'h00;
         end
      endcase
   end

   assign frame_done = fd_q;
   assign err        = err_q;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Bench for bcd_disp_mux: directed scenarios plus random traffic against a
// slot-arithmetic reference model (enabled-edge count -> digit slot).
module tb_bcd_disp_mux;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] bcd_in = 8'h00;
   logic       blank_lz = 1'b0;
   logic [1:0] an;
   logic [6:0] seg;
   logic       frame_done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int         m_run;
   logic [7:0] m_snap;
   logic       m_lz;
   logic       m_err;
   logic       m_fd;
   logic [6:0] tbl [16];

   bcd_disp_mux #(.REFRESH_DIV(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .bcd_in     (bcd_in),
      .blank_lz   (blank_lz),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // slot 0 = first ONES slot after run reaches D; even slots ONES, odd TENS
   function automatic int m_slot();
      return (m_run < D) ? -1 : (m_run - D) / D;
   endfunction

   function automatic logic [1:0] m_an();
      int s = m_slot();
      if (s < 0) return 2'b00;
      return (s % 2 == 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [6:0] m_seg();
      int s = m_slot();
      int tens = m_snap / 16;
      int ones = m_snap % 16;
      if (s < 0) return 7'h00;
      if (s % 2 == 0) return tbl[ones];
      if (m_lz && tens == 0) return 7'h00;
      return tbl[tens];
   endfunction

   task automatic step(input logic r, input logic e, input logic [7:0] b, input logic z);
      rst = r; en = e; bcd_in = b; blank_lz = z;
      @(posedge clk);
      if (r) begin
         m_run = 0; m_snap = 8'h00; m_lz = 1'b0; m_err = 1'b0; m_fd = 1'b0;
      end else if (!e) begin
         m_run = 0; m_fd = 1'b0;
      end else begin
         m_run++;
         m_fd = 1'b0;
         if (m_run >= D && (m_run - D) % D == 0 && ((m_run - D) / D) % 2 == 0) begin
            m_snap = b;
            m_lz   = z;
            m_err  = (b / 16 > 9) || (b % 16 > 9);
            m_fd   = (m_run > D);
         end
      end
      #1;
      check("an",         {6'd0, an},         {6'd0, m_an()});
      check("seg",        {1'b0, seg},        {1'b0, m_seg()});
      check("frame_done", {7'd0, frame_done}, {7'd0, m_fd});
      check("err",        {7'd0, err},        {7'd0, m_err});
   endtask

   task automatic run_n(input int n, input logic [7:0] b, input logic z);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, b, z);
   endtask

   initial begin
      tbl[0] = 7'h3F; tbl[1] = 7'h06; tbl[2] = 7'h5B; tbl[3] = 7'h4F;
      tbl[4] = 7'h66; tbl[5] = 7'h6D; tbl[6] = 7'h7D; tbl[7] = 7'h07;
      tbl[8] = 7'h7F; tbl[9] = 7'h6F;
      for (int i = 10; i < 16; i++) tbl[i] = 7'h40;
      m_run = 0; m_snap = 8'h00; m_lz = 1'b0; m_err = 1'b0; m_fd = 1'b0;

      // startup
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check("rst_an", {6'd0, an}, 8'h00);
      check("rst_seg", {1'b0, seg}, 8'h00);
      run_n(3, 8'h99, 1'b0);
      check("start_idle_an", {6'd0, an}, 8'h00);
      run_n(1, 8'h99, 1'b0);
      check("start_ones_an", {6'd0, an}, 8'h01);
      check("start_ones_seg", {1'b0, seg}, 8'h6F);
      run_n(4, 8'h99, 1'b0);
      check("start_tens_an", {6'd0, an}, 8'h02);
      check("start_tens_seg", {1'b0, seg}, 8'h6F);
      run_n(4, 8'h99, 1'b0);
      check("start_fd", {7'd0, frame_done}, 8'h01);
      check("start_fd_an", {6'd0, an}, 8'h01);
      run_n(1, 8'h99, 1'b0);
      check("start_fd_clr", {7'd0, frame_done}, 8'h00);

      // tear-free snapshot
      step(1'b1, 1'b0, 8'h00, 1'b0);
      run_n(8, 8'h42, 1'b0);
      check("tear_tens", {1'b0, seg}, 8'h66);
      run_n(3, 8'h41, 1'b0);
      check("tear_hold", {1'b0, seg}, 8'h66);
      run_n(1, 8'h41, 1'b0);
      check("tear_next_ones", {1'b0, seg}, 8'h06);

      // leading-zero blanking
      step(1'b1, 1'b0, 8'h00, 1'b0);
      run_n(4, 8'h07, 1'b1);
      check("lz_ones", {1'b0, seg}, 8'h07);
      run_n(4, 8'h07, 1'b1);
      check("lz_tens_an", {6'd0, an}, 8'h02);
      check("lz_tens_seg", {1'b0, seg}, 8'h00);
      run_n(8, 8'h07, 1'b0);
      check("nolz_tens_seg", {1'b0, seg}, 8'h3F);

      // invalid BCD
      step(1'b1, 1'b0, 8'h00, 1'b0);
      run_n(4, 8'hA5, 1'b0);
      check("bad_err", {7'd0, err}, 8'h01);
      check("bad_ones", {1'b0, seg}, 8'h6D);
      run_n(4, 8'hA5, 1'b0);
      check("bad_tens", {1'b0, seg}, 8'h40);
      run_n(4, 8'h35, 1'b0);
      check("bad_clear", {7'd0, err}, 8'h00);

      // enable drop mid-ONES
      step(1'b1, 1'b0, 8'h00, 1'b0);
      run_n(5, 8'h12, 1'b0);
      step(1'b0, 1'b0, 8'h12, 1'b0);
      check("endrop_an", {6'd0, an}, 8'h00);
      check("endrop_seg", {1'b0, seg}, 8'h00);
      run_n(3, 8'h12, 1'b0);
      check("reen_idle", {6'd0, an}, 8'h00);
      run_n(1, 8'h12, 1'b0);
      check("reen_ones", {6'd0, an}, 8'h01);

      // reset mid-TENS
      step(1'b1, 1'b0, 8'h00, 1'b0);
      run_n(9, 8'hA5, 1'b0);
      check("midrst_pre_err", {7'd0, err}, 8'h01);
      step(1'b1, 1'b1, 8'hA5, 1'b0);
      check("midrst_an", {6'd0, an}, 8'h00);
      check("midrst_err", {7'd0, err}, 8'h00);
      check("midrst_fd", {7'd0, frame_done}, 8'h00);
      run_n(8, 8'h00, 1'b0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) != 0),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_disp_mux.md
BCD_DISP_MUX -- requirements
Module: bcd_disp_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 4, clk cycles per digit slot; legal range 2..65536; prescaler width = clog2(REFRESH_DIV).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high; sampled only at posedge clk.
REQ-004 en  input  1  scan enable; 0 forces idle/blank.
REQ-005 bcd_in  input  8  packed BCD count {tens[7:4], ones[3:0]} from the upstream BCD counter.
REQ-006 blank_lz  input  1  1 = blank tens digit when it is 0.
REQ-007 an  output  2  digit select, active-high; an[0] = ones digit, an[1] = tens digit; one-hot or 00.
REQ-008 seg  output  7  segments, active-high, {g,f,e,d,c,b,a}.
REQ-009 frame_done  output  1  one-cycle pulse at the end of each complete ones+tens scan.
REQ-010 err  output  1  latched snapshot contained a nibble > 9.

Function
REQ-011 Prescaler cnt shall count 0..REFRESH_DIV-1 while en=1 and wrap to 0; tick = (en && cnt==REFRESH_DIV-1).
REQ-012 FSM states: IDLE, ONES, TENS.
- IDLE->ONES on tick.
- ONES->TENS on tick.
- TENS->ONES on tick.
- Otherwise hold.
REQ-013 en=0 at an edge shall force state=IDLE and cnt=0 at that edge; snapshot, blank_lz copy and err shall hold.
REQ-014 Snapshot register snap[7:0] and lz register shall load bcd_in and blank_lz on ticks from IDLE->ONES and TENS->ONES only; never mid-frame.
REQ-015 err shall load (snap_next[7:4]>9 || snap_next[3:0]>9) on the same edges as snap; otherwise hold.
REQ-016 frame_done shall be a registered pulse, 1 for exactly the cycle after the TENS->ONES edge; 0 on IDLE->ONES.
REQ-017 an shall be decoded from the state register only:
- IDLE=00.
- ONES=01.
- TENS=10.
REQ-018 seg shall be decoded from the state, snap and lz registers only, with no combinational path from bcd_in or blank_lz.
- IDLE: 0x00.
- ONES: decode(snap[3:0]).
- TENS: decode(snap[7:4]), except 0x00 when lz=1 and snap[7:4]==0.
REQ-019 Segment decode values:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66.
- 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Any nibble A-F = 40 (dash).
REQ-020 Leading-zero blanking shall not alter an (tens slot is still selected, dark).
REQ-021 Dwell per digit shall be exactly REFRESH_DIV cycles in steady state; first ONES slot entered on the REFRESH_DIV-th enabled edge after reset or en re-assertion.

Reset
REQ-022 rst=1 at an edge shall set state=IDLE, cnt=0, snap=8'h00, lz=0, err=0, frame_done=0, giving an=00 and seg=0x00.
REQ-023 rst shall take priority over en and tick at the same edge; mid-frame reset shall abort the scan with no frame_done.

Verification (REFRESH_DIV=4)
REQ-024 Startup: rst 1 cycle, then en=1, bcd_in=8'h99 -> an=00 for 4 edges; then an=01/seg=6F for 4 cycles; an=10/seg=6F for 4 cycles; frame_done=1 for one cycle as an returns to 01.
REQ-025 Tear-free: bcd_in=8'h42 latched, change to 8'h41 during the TENS slot -> remainder of frame shows 4/2; next ONES slot shows 06 (1).
REQ-026 Blanking: bcd_in=8'h07, blank_lz=1 -> ONES seg=07, TENS an=10 with seg=00; with blank_lz=0, TENS seg=3F.
REQ-027 Invalid BCD: bcd_in=8'hA5 -> err=1 from the latch edge; ONES seg=6D, TENS seg=40; a later 8'h35 latch clears err.
REQ-028 Enable drop: en=0 mid-ONES slot -> next edge an=00, seg=00, cnt=0; re-assert en -> ONES again after exactly 4 edges.
REQ-029 Reset mid-TENS with en=1 -> next edge an=00, err=0, snap=00, frame_done stays 0.
